// File: rtl/child_link_pkg.sv
// Shared definitions for the CHILD serial link: state encoding, line levels and
// frame-length arithmetic used by both the transmitter and a matching receiver.
package child_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int data_w, input int parity_en,
                                      input int clks_per_bit);
    return (2 + data_w + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/child_tx_baud.sv
// Bit-period timer: counts CLKS_PER_BIT clocks while enabled and pulses
// bit_done on the last clock of every serial bit.
module child_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (bit_done) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/child_tx.sv
// Serial transmitter for the CHILD I pin: accepts words over valid/ready and
// sends start, LSB-first data, optional even parity and stop bits.
module child_tx
  import child_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              O,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shift, shift_nx, shift_shr;
  logic [BW-1:0]     bit_cnt, bit_cnt_nx;
  logic              parity, parity_nx;
  logic              o_nx, busy_nx, ready_nx;
  logic              bit_done;

  assign shift_shr = shift >> 1;

  child_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .en       (state != IDLE),
    .bit_done (bit_done)
  );

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    parity_nx  = parity;
    o_nx       = O;
    busy_nx    = busy;
    ready_nx   = in_ready;
    case (state)
      IDLE: begin
        o_nx     = LINE_IDLE;
        busy_nx  = 1'b0;
        ready_nx = 1'b1;
        if (in_valid && in_ready) begin
          shift_nx   = in_data;
          parity_nx  = ^in_data;
          bit_cnt_nx = '0;
          ready_nx   = 1'b0;
          busy_nx    = 1'b1;
          o_nx       = 1'b0;
          state_nx   = START;
        end
      end
      START: begin
        if (bit_done) begin
          o_nx     = shift[0];
          state_nx = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_nx = shift_shr;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nx = '0;
            if (PARITY_EN != 0) begin
              o_nx     = parity;
              state_nx = PARITY;
            end else begin
              o_nx     = LINE_IDLE;
              state_nx = STOP;
            end
          end else begin
            // The line register is loaded with the bit that follows the shift.
            bit_cnt_nx = bit_cnt + BW'(1);
            o_nx       = shift_shr[0];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          o_nx     = LINE_IDLE;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          o_nx     = LINE_IDLE;
          busy_nx  = 1'b0;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the shift register is a plain register, not a memory array, so it
  // is cleared with the rest of the state on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      parity   <= 1'b0;
      O        <= LINE_IDLE;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      shift    <= shift_nx;
      bit_cnt  <= bit_cnt_nx;
      parity   <= parity_nx;
      O        <= o_nx;
      busy     <= busy_nx;
      in_ready <= ready_nx;
    end
  end

endmodule

// File: tb/tb_child_tx.sv
// Self-checking bench for child_tx: a frame-level model checked every cycle
// against a default instance and a 4-bit, 1-clock-per-bit, no-parity instance.
module tb_child_tx;

  localparam int DW_A = 8, CPB_A = 4, PE_A = 1;
  localparam int DW_B = 4, CPB_B = 1, PE_B = 0;
  localparam int FRAME_A = (2 + DW_A + PE_A) * CPB_A;
  localparam int FRAME_B = (2 + DW_B + PE_B) * CPB_B;

  logic       clk;
  logic       rst_n, rst_n_b;
  logic [7:0] in_data_a;
  logic [3:0] in_data_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       o_a, o_b, busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  child_tx #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A), .PARITY_EN(PE_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .O(o_a), .busy(busy_a));

  child_tx #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB_B), .PARITY_EN(PE_B)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .O(o_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level at frame position pos (0 = start bit) for a word w.
  function automatic logic line_bit(input logic [31:0] w, input int pos,
                                    input int dw, input int pe);
    if (pos == 0) return 1'b0;
    if (pos <= dw) return w[pos-1];
    if (pe != 0 && pos == dw + 1) return ^w;
    return 1'b1;
  endfunction

  // Frame-level model: a frame is a run of cycles indexed from the handshake.
  bit          ma_on, ma_act, ma_rdy, mb_on, mb_act, mb_rdy;
  int          ma_cyc, mb_cyc;
  logic [31:0] ma_word, mb_word;

  always @(posedge clk) begin
    ma_on = 1'b1;
    if (!rst_n) begin
      ma_act = 1'b0; ma_rdy = 1'b0; ma_cyc = 0;
    end else if (ma_act) begin
      ma_cyc++;
      if (ma_cyc == FRAME_A) begin ma_act = 1'b0; ma_rdy = 1'b1; end
    end else if (ma_rdy && in_valid_a) begin
      ma_act = 1'b1; ma_rdy = 1'b0; ma_cyc = 0; ma_word = 32'(in_data_a);
    end else begin
      ma_rdy = 1'b1;
    end
  end

  always @(posedge clk) begin
    mb_on = 1'b1;
    if (!rst_n_b) begin
      mb_act = 1'b0; mb_rdy = 1'b0; mb_cyc = 0;
    end else if (mb_act) begin
      mb_cyc++;
      if (mb_cyc == FRAME_B) begin mb_act = 1'b0; mb_rdy = 1'b1; end
    end else if (mb_rdy && in_valid_b) begin
      mb_act = 1'b1; mb_rdy = 1'b0; mb_cyc = 0; mb_word = 32'(in_data_b);
    end else begin
      mb_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (ma_on) begin
      check("a_line", o_a, ma_act ? line_bit(ma_word, ma_cyc / CPB_A, DW_A, PE_A) : 1'b1);
      check("a_busy", busy_a, ma_act);
      check("a_ready", in_ready_a, ma_rdy);
    end
    if (mb_on) begin
      check("b_line", o_b, mb_act ? line_bit(mb_word, mb_cyc / CPB_B, DW_B, PE_B) : 1'b1);
      check("b_busy", busy_b, mb_act);
      check("b_ready", in_ready_b, mb_rdy);
    end
  end

  // Offers a word on A and returns at the negedge after the handshake edge.
  task automatic send_a(input logic [7:0] d, input bit keep_valid);
    int w = 0;
    in_data_a  = d;
    in_valid_a = 1'b1;
    while (in_ready_a !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("a_ready_wait", in_ready_a, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) in_valid_a = 1'b0;
  endtask

  // Samples the middle of each bit of the frame on A, starting at this negedge.
  task automatic capture_a(output logic [10:0] bits, output int n_busy);
    bits   = '0;
    n_busy = 0;
    for (int k = 0; k < 200 && busy_a === 1'b1; k++) begin
      if (k % CPB_A == CPB_A / 2 && k / CPB_A < 11) bits[k / CPB_A] = o_a;
      n_busy++;
      @(negedge clk);
    end
  endtask

  logic [10:0] bits;
  logic [5:0]  bits_b;
  int          nb, idle, w;

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_data_a = '0; in_data_b = '0;

    // Reset held for three edges, then released.
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready_a, 1'b0);
    check("rst_line", o_a, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", in_ready_a, 1'b1);
    repeat (2) @(negedge clk);

    // Single frame, even parity.
    send_a(8'hA5, 1'b0);
    capture_a(bits, nb);
    check("a5_bits", bits, 11'h54A);
    check("a5_busy_cycles", nb, FRAME_A);
    check("a5_ready_after", in_ready_a, 1'b1);

    // Odd parity; input changes mid-frame must not disturb the frame.
    send_a(8'h01, 1'b0);
    fork
      capture_a(bits, nb);
      begin repeat (10) @(negedge clk); in_data_a = 8'hFF; end
    join
    check("01_bits", bits, 11'h602);
    check("01_busy_cycles", nb, FRAME_A);

    // Back-to-back with in_valid held high through the first frame.
    send_a(8'h3C, 1'b1);
    in_data_a = 8'hC3;
    w = 0;
    while (busy_a === 1'b1 && w < 200) begin @(negedge clk); w++; end
    idle = 0;
    while (busy_a === 1'b0 && idle < 10) begin
      check("b2b_idle_line", o_a, 1'b1);
      idle++;
      @(negedge clk);
    end
    check("b2b_idle_cycles", idle, 1);
    in_valid_a = 1'b0;
    capture_a(bits, nb);
    check("c3_bits", bits, 11'h586);
    check("c3_busy_cycles", nb, FRAME_A);
    repeat (3) @(negedge clk);

    // Reset during the third data bit, then a clean frame.
    send_a(8'hA5, 1'b0);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_line", o_a, 1'b1);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_ready", in_ready_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_a(8'h5A, 1'b0);
    capture_a(bits, nb);
    check("5a_bits", bits, 11'h4B4);
    check("5a_busy_cycles", nb, FRAME_A);

    // One clock per bit, four data bits, no parity.
    rst_n_b = 1'b1;
    @(negedge clk);
    in_data_b  = 4'hB;
    in_valid_b = 1'b1;
    check("b_ready_before", in_ready_b, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bits_b[k] = o_b;
      @(negedge clk);
    end
    check("b_bits", bits_b, 6'h36);
    check("b_idle_line", o_b, 1'b1);
    check("b_idle_busy", busy_b, 1'b0);
    check("b_idle_ready", in_ready_b, 1'b1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
